// File: rtl/k16_panel_defs.sv
// Shared K16 front-panel definitions: register offsets, command codes, FSM states.
// The CPU monitor decodes the same command codes, so this package is their single source.
package k16_panel_defs;

   // Register offsets from BASE_ADDR
   localparam logic [2:0] OFF_ADDR_SW  = 3'd0;
   localparam logic [2:0] OFF_CTRL_SW  = 3'd1;
   localparam logic [2:0] OFF_REG_SW   = 3'd2;
   localparam logic [2:0] OFF_ADDR_LED = 3'd3;
   localparam logic [2:0] OFF_DATA_LED = 3'd4;

   // Control commands; button index i maps to command code i+1
   typedef enum logic [2:0] {
      CMD_NONE             = 3'd0,
      CMD_INST_STEP        = 3'd1,
      CMD_EXAMINE          = 3'd2,
      CMD_EXAMINE_NEXT     = 3'd3,
      CMD_DEPOSIT          = 3'd4,
      CMD_DEPOSIT_NEXT     = 3'd5,
      CMD_EXAMINE_REGISTER = 3'd6,
      CMD_DEPOSIT_REGISTER = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_HOLD    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_e;

   // Lowest-index pressed button wins when several are seen together
   function automatic cmd_e lowest_cmd(input logic [6:0] b);
      lowest_cmd = CMD_NONE;
      for (int i = 6; i >= 0; i--) begin
         if (b[i]) lowest_cmd = cmd_e'(3'(i + 1));
      end
   endfunction

endpackage

// File: rtl/k16_debounce.sv
// Two-flop synchronizer followed by a whole-vector stability counter.
// Any change of the synchronized value restarts the count; the value is accepted
// once it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module k16_debounce #(
   parameter int          WIDTH           = 1,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [15:0]      cnt;

   // Synchronize, track the candidate value and count how long it has held
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         cand   <= '0;
         cnt    <= '0;
         stable <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= 16'd1;
         end else begin
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (cnt >= DEBOUNCE_CYCLES - 16'd1) stable <= cand;
         end
      end
   end

endmodule

// File: rtl/k16_front_panel.sv
// K16 front-panel bus responder: switch registers, LED registers and the
// button-to-command FSM. Optional build macro K16_PANEL_SW_WRITE_EN lets CPU
// writes override the switch registers and force CTRL (simulation/self-test).
module k16_front_panel
   import k16_panel_defs::*;
#(
   parameter logic [15:0] BASE_ADDR       = 16'hFFF8,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] HOLD_CYCLES     = 16'd64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] data_out,
   input  logic        write,
   output logic [15:0] data_in,
   output logic        sel,
   input  logic [15:0] sw_addr,
   input  logic [2:0]  sw_reg,
   input  logic [6:0]  btn,
   output logic [15:0] led_addr,
   output logic [15:0] led_data
);

   logic [15:0] sw_addr_db;
   logic [2:0]  sw_reg_db;
   logic [6:0]  btn_db;
   logic [15:0] addr_sw;
   logic [2:0]  reg_sw;
   logic [15:0] offset;
   logic [2:0]  reg_sel;
   logic        hit;
   logic        wr_en;
   logic [15:0] rd_mux;
   state_e      state;
   cmd_e        ctrl;
   logic [15:0] hold_cnt;

   k16_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_addr (
      .clk(clk), .reset(reset), .raw(sw_addr), .stable(sw_addr_db)
   );

   k16_debounce #(.WIDTH(3), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reg (
      .clk(clk), .reset(reset), .raw(sw_reg), .stable(sw_reg_db)
   );

   for (genvar i = 0; i < 7; i++) begin : g_btn
      k16_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
         .clk(clk), .reset(reset), .raw(btn[i]), .stable(btn_db[i])
      );
   end

   // Subtracting the base makes the window check immune to address wrap
   assign offset  = address - BASE_ADDR;
   assign hit     = (offset <= 16'd4);
   assign reg_sel = offset[2:0];
   assign wr_en   = write & hit;

`ifdef K16_PANEL_SW_WRITE_EN
   logic        addr_ovr;
   logic        reg_ovr;
   logic [15:0] addr_ovr_val;
   logic [2:0]  reg_ovr_val;
   logic [15:0] addr_db_q;
   logic [2:0]  reg_db_q;

   // CPU writes shadow the switch registers until the debounced pins move
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_ovr     <= 1'b0;
         reg_ovr      <= 1'b0;
         addr_ovr_val <= '0;
         reg_ovr_val  <= '0;
         addr_db_q    <= '0;
         reg_db_q     <= '0;
      end else begin
         addr_db_q <= sw_addr_db;
         reg_db_q  <= sw_reg_db;
         if (wr_en && reg_sel == OFF_ADDR_SW) begin
            addr_ovr     <= 1'b1;
            addr_ovr_val <= data_out;
         end else if (sw_addr_db != addr_db_q) begin
            addr_ovr <= 1'b0;
         end
         if (wr_en && reg_sel == OFF_REG_SW) begin
            reg_ovr     <= 1'b1;
            reg_ovr_val <= data_out[2:0];
         end else if (sw_reg_db != reg_db_q) begin
            reg_ovr <= 1'b0;
         end
      end
   end

   assign addr_sw = addr_ovr ? addr_ovr_val : sw_addr_db;
   assign reg_sw  = reg_ovr  ? reg_ovr_val  : sw_reg_db;
`else
   assign addr_sw = sw_addr_db;
   assign reg_sw  = sw_reg_db;
`endif

   // Read mux over the five registers; CTRL is the pre-edge command
   always_comb begin
      // NOTE: default first so no path leaves rd_mux unassigned (no latch).
      rd_mux = '0;
      case (reg_sel)
         OFF_ADDR_SW:  rd_mux = addr_sw;
         OFF_CTRL_SW:  rd_mux = {13'd0, ctrl};
         OFF_REG_SW:   rd_mux = {13'd0, reg_sw};
         OFF_ADDR_LED: rd_mux = led_addr;
         OFF_DATA_LED: rd_mux = led_data;
         default:      rd_mux = '0;
      endcase
   end

   // Registered bus read path and LED register writes; reset beats a write
   always_ff @(posedge clk) begin
      if (reset) begin
         data_in  <= '0;
         sel      <= 1'b0;
         led_addr <= '0;
         led_data <= '0;
      end else begin
         sel     <= hit;
         data_in <= hit ? rd_mux : 16'h0000;
         if (wr_en && reg_sel == OFF_ADDR_LED) led_addr <= data_out;
         if (wr_en && reg_sel == OFF_DATA_LED) led_data <= data_out;
      end
   end

   // Command FSM: latch a press, hold it after release, then force a NONE gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ctrl     <= CMD_NONE;
         hold_cnt <= '0;
      end else begin
`ifdef K16_PANEL_SW_WRITE_EN
         if (wr_en && reg_sel == OFF_CTRL_SW) begin
            ctrl     <= cmd_e'(data_out[2:0]);
            state    <= (data_out[2:0] == 3'd0) ? ST_IDLE : ST_ACTIVE;
            hold_cnt <= '0;
         end else
`endif
         begin
            case (state)
               ST_IDLE: begin
                  if (|btn_db) begin
                     state <= ST_ACTIVE;
                     ctrl  <= lowest_cmd(btn_db);
                  end
               end
               ST_ACTIVE: begin
                  if (btn_db == '0) begin
                     state    <= ST_HOLD;
                     hold_cnt <= HOLD_CYCLES;
                  end
               end
               ST_HOLD: begin
                  // Leaving at 1 gives exactly HOLD_CYCLES cycles in HOLD
                  if (hold_cnt <= 16'd1) begin
                     state    <= ST_LOCKOUT;
                     ctrl     <= CMD_NONE;
                     hold_cnt <= 16'd1;
                  end else begin
                     hold_cnt <= hold_cnt - 16'd1;
                  end
               end
               ST_LOCKOUT: begin
                  if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
                  else if (btn_db == '0) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
